// File: rtl/map_tile_writer.sv
// map_tile_writer
//
// Write-side controller for the playfield tile map. After reset it streams
// the default level layout into the external tile RAM, then services hit
// requests. Each request is a pixel coordinate that is converted to a tile
// address. The tile is read, a brick is rewritten to background, and the
// outcome is reported on a one-cycle response strobe.
//
// Handshake: a request is taken at a rising edge where HitValid && HitReady.
// HitReady is high only in IDLE. HitX/HitY are sampled on that edge only.
// RespValid is a one-cycle strobe with no backpressure.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   HitValid/HitReady   request handshake
//   HitX, HitY          request pixel coordinate (10 bits each)
//   RespValid/RespCode  response: 00 EMPTY, 01 BRICK_DESTROYED, 10 BLOCKED,
//                       11 OUT_OF_BOUNDS
//   MapAddr             tile RAM address (row*COLS + col)
//   MapRe/MapWe         tile RAM read / write enables (never both high)
//   MapWrData           tile code written
//   MapRdData           tile RAM read data, valid the cycle after MapRe
//   InitDone            high once the layout load completes
//   DbgState            current FSM state, for checkers
//
// All outputs are registered, computed from the next state, so they drop to
// their reset values the moment Reset_n falls.

module map_tile_writer (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       HitValid,
  input  logic [9:0] HitX,
  input  logic [9:0] HitY,
  output logic       HitReady,
  output logic       RespValid,
  output logic [1:0] RespCode,
  output logic [9:0] MapAddr,
  output logic       MapRe,
  output logic       MapWe,
  output logic [2:0] MapWrData,
  input  logic [2:0] MapRdData,
  output logic       InitDone,
  output logic [2:0] DbgState
);

  localparam int TILE_PX = 20;
  localparam int COLS    = 32;
  localparam int ROWS    = 24;

  // Counter value one past the last layout address. The write for address
  // COLS*ROWS-1 is presented while the counter holds this value's
  // predecessor, so leaving INIT here lets the final write complete before
  // InitDone and HitReady rise together.
  localparam logic [9:0] INIT_END = 10'(COLS * ROWS);
  localparam logic [9:0] X_LIMIT  = 10'(COLS * TILE_PX);
  localparam logic [9:0] Y_LIMIT  = 10'(ROWS * TILE_PX);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // Default level layout indexed by address = {row, col}.
  function automatic logic [2:0] layout_code(input logic [9:0] addr);
    logic [4:0] r;
    logic [4:0] c;
    r = addr[9:5];
    c = addr[4:0];
    if (r == 5'd0 || r == 5'd23 || c == 5'd0 || c == 5'd31)
      return 3'b011;
    if (r == 5'd5 && c >= 5'd5 && c <= 5'd10)
      return 3'b001;
    if (r == 5'd15 && c >= 5'd15 && c <= 5'd18)
      return 3'b001;
    if (r == 5'd20 && c >= 5'd20 && c <= 5'd23)
      return 3'b001;
    if (r == 5'd10 && c >= 5'd12 && c <= 5'd19)
      return 3'b010;
    return 3'b000;
  endfunction

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [4:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic       init_done_q, init_done_d;
  logic       hit_ready_q, hit_ready_d;
  logic       resp_valid_q, resp_valid_d;
  logic [1:0] resp_code_q, resp_code_d;
  logic [9:0] map_addr_q, map_addr_d;
  logic       map_re_q, map_re_d;
  logic       map_we_q, map_we_d;
  logic [2:0] map_wr_data_q, map_wr_data_d;

  logic [4:0] col_calc;
  logic [4:0] row_calc;
  logic       oob;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    col_d         = col_q;
    init_done_d   = init_done_q;
    hit_ready_d   = 1'b0;
    resp_valid_d  = 1'b0;
    resp_code_d   = 2'b00;
    map_addr_d    = map_addr_q;
    map_re_d      = 1'b0;
    map_we_d      = 1'b0;
    map_wr_data_d = 3'b000;

    // floor(v/20) as (v*205)>>12: the error term stays below 0.032 for
    // v <= 639, smaller than the 1/20 gap to the next integer.
    col_calc = 5'((17'(HitX) * 17'd205) >> 12);
    row_calc = 5'((17'(HitY) * 17'd205) >> 12);
    oob      = (HitX >= X_LIMIT) || (HitY >= Y_LIMIT);

    case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_END) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
          hit_ready_d = 1'b1;
        end else begin
          map_we_d      = 1'b1;
          map_addr_d    = cnt_q;
          map_wr_data_d = layout_code(cnt_q);
          cnt_d         = cnt_q + 10'd1;
        end
      end
      S_IDLE: begin
        if (HitValid) begin
          if (oob) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_code_d  = 2'b11;
          end else begin
            row_d      = row_calc;
            col_d      = col_calc;
            state_d    = S_READ;
            map_re_d   = 1'b1;
            // COLS is 32, so row*COLS + col is the plain concatenation.
            map_addr_d = {row_calc, col_calc};
          end
        end else begin
          hit_ready_d = 1'b1;
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        case (MapRdData)
          3'b001: begin
            state_d  = S_WRITE;
            map_we_d = 1'b1;
          end
          3'b011: begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_code_d  = 2'b10;
          end
          default: begin
            // Background and grass both let the bullet through.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_code_d  = 2'b00;
          end
        endcase
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_code_d  = 2'b01;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        hit_ready_d = 1'b1;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = 10'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_INIT;
      cnt_q         <= 10'd0;
      row_q         <= 5'd0;
      col_q         <= 5'd0;
      init_done_q   <= 1'b0;
      hit_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_code_q   <= 2'b00;
      map_addr_q    <= 10'd0;
      map_re_q      <= 1'b0;
      map_we_q      <= 1'b0;
      map_wr_data_q <= 3'b000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      col_q         <= col_d;
      init_done_q   <= init_done_d;
      hit_ready_q   <= hit_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_code_q   <= resp_code_d;
      map_addr_q    <= map_addr_d;
      map_re_q      <= map_re_d;
      map_we_q      <= map_we_d;
      map_wr_data_q <= map_wr_data_d;
    end
  end

  assign HitReady  = hit_ready_q;
  assign RespValid = resp_valid_q;
  assign RespCode  = resp_code_q;
  assign MapAddr   = map_addr_q;
  assign MapRe     = map_re_q;
  assign MapWe     = map_we_q;
  assign MapWrData = map_wr_data_q;
  assign InitDone  = init_done_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_map_tile_writer.sv
// Bench for map_tile_writer: tile RAM model, layout/map model, scoreboard
// queues for responses, reads and writes, directed steps in one initial.

module tb_map_tile_writer;

  logic       Clk;
  logic       Reset_n;
  logic       HitValid;
  logic [9:0] HitX;
  logic [9:0] HitY;
  logic       HitReady;
  logic       RespValid;
  logic [1:0] RespCode;
  logic [9:0] MapAddr;
  logic       MapRe;
  logic       MapWe;
  logic [2:0] MapWrData;
  logic [2:0] MapRdData;
  logic       InitDone;
  logic [2:0] DbgState;

  map_tile_writer dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .HitValid  (HitValid),
    .HitX      (HitX),
    .HitY      (HitY),
    .HitReady  (HitReady),
    .RespValid (RespValid),
    .RespCode  (RespCode),
    .MapAddr   (MapAddr),
    .MapRe     (MapRe),
    .MapWe     (MapWe),
    .MapWrData (MapWrData),
    .MapRdData (MapRdData),
    .InitDone  (InitDone),
    .DbgState  (DbgState)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- tile RAM model ----------------
  logic [2:0] ram [0:767];
  logic [2:0] rd_data;
  assign MapRdData = rd_data;

  always @(posedge Clk) begin
    if (MapWe) ram[MapAddr] <= MapWrData;
    if (MapRe) rd_data <= ram[MapAddr];
  end

  // ---------------- reference layout and live map ----------------
  logic [2:0] lay [0:767];
  logic [2:0] mdl [0:767];

  task automatic build_layout();
    for (int i = 0; i < 768; i++) lay[i] = 3'b000;
    for (int c = 5; c <= 10; c++) lay[5*32 + c] = 3'b001;
    for (int c = 15; c <= 18; c++) lay[15*32 + c] = 3'b001;
    for (int c = 20; c <= 23; c++) lay[20*32 + c] = 3'b001;
    for (int c = 12; c <= 19; c++) lay[10*32 + c] = 3'b010;
    for (int c = 0; c < 32; c++) begin
      lay[c] = 3'b011;
      lay[23*32 + c] = 3'b011;
    end
    for (int r = 0; r < 24; r++) begin
      lay[r*32] = 3'b011;
      lay[r*32 + 31] = 3'b011;
    end
  endtask

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];
  int         lat_q[$];
  int         acc_q[$];
  logic [9:0] rd_q[$];
  logic [9:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    rd_q.delete();
    wr_q.delete();
  endtask

  // Expected outcome of a request accepted at the coming rising edge.
  task automatic predict(input int x, input int y);
    int addr;
    logic [1:0] code;
    int lat;
    if (x >= 640 || y >= 480) begin
      code = 2'b11;
      lat = 1;
    end else begin
      addr = (y / 20) * 32 + (x / 20);
      rd_q.push_back(10'(addr));
      if (mdl[addr] == 3'b001) begin
        code = 2'b01;
        lat = 4;
        mdl[addr] = 3'b000;
        wr_q.push_back(10'(addr));
      end else if (mdl[addr] == 3'b011) begin
        code = 2'b10;
        lat = 3;
      end else begin
        code = 2'b00;
        lat = 3;
      end
    end
    exp_q.push_back(code);
    lat_q.push_back(lat);
    acc_q.push_back(cyc + 1);
  endtask

  // ---------------- monitor ----------------
  int init_cnt = 0;
  bit done_seen = 0;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      init_cnt = 0;
      done_seen = 0;
    end else begin
      if (MapRe || MapWe)
        check("re_we_exclusive", 32'(MapRe & MapWe), 32'd0);
      if (MapWe && !InitDone) begin
        if (init_cnt < 768) begin
          check("init_addr", 32'(MapAddr), 32'(init_cnt));
          check("init_data", 32'(MapWrData), 32'(lay[init_cnt]));
        end else begin
          check("init_overrun", 32'(init_cnt), 32'd767);
        end
        init_cnt++;
      end
      if (InitDone && !done_seen) begin
        done_seen = 1;
        check("init_count", 32'(init_cnt), 32'd768);
        check("init_last_write_done", 32'(MapWe), 32'd0);
      end
      if (MapWe && InitDone) begin
        if (wr_q.size() == 0) check("write_expected", 32'(wr_q.size()), 32'd1);
        else begin
          check("write_addr", 32'(MapAddr), 32'(wr_q.pop_front()));
          check("write_data", 32'(MapWrData), 32'd0);
        end
      end
      if (MapRe) begin
        if (rd_q.size() == 0) check("read_expected", 32'(rd_q.size()), 32'd1);
        else check("read_addr", 32'(MapAddr), 32'(rd_q.pop_front()));
      end
      if (RespValid) begin
        if (exp_q.size() == 0) check("resp_expected", 32'(exp_q.size()), 32'd1);
        else begin
          check("resp_code", 32'(RespCode), 32'(exp_q.pop_front()));
          check("resp_latency", 32'(cyc - acc_q.pop_front()), 32'(lat_q.pop_front() - 1));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hit(input int x, input int y);
    int n;
    n = 0;
    @(negedge Clk);
    HitX = 10'(x);
    HitY = 10'(y);
    HitValid = 1'b1;
    while (!HitReady && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    if (!HitReady) begin
      check("accept_timeout", 32'(HitReady), 32'd1);
      HitValid = 1'b0;
    end else begin
      check("accept_after_init", 32'(InitDone), 32'd1);
      predict(x, y);
      @(posedge Clk);
      #1;
      HitValid = 1'b0;
      // Scramble the coordinate: the in-flight request must not see it.
      HitX = 10'($urandom_range(0, 1023));
      HitY = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge Clk);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!InitDone && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    check("init_done", 32'(InitDone), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_hit_ready", 32'(HitReady), 32'd0);
    check("rst_resp_valid", 32'(RespValid), 32'd0);
    check("rst_resp_code", 32'(RespCode), 32'd0);
    check("rst_map_addr", 32'(MapAddr), 32'd0);
    check("rst_map_re", 32'(MapRe), 32'd0);
    check("rst_map_we", 32'(MapWe), 32'd0);
    check("rst_wr_data", 32'(MapWrData), 32'd0);
    check("rst_init_done", 32'(InitDone), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    Reset_n = 1'b1;
    HitValid = 1'b0;
    HitX = 10'd0;
    HitY = 10'd0;
    build_layout();
    mdl = lay;

    // Reset and layout load
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    wait_init();
    check("ram_165_brick", 32'(ram[165]), 32'd1);
    check("ram_0_steel", 32'(ram[0]), 32'd3);
    check("ram_332_grass", 32'(ram[332]), 32'd2);
    check("ram_767_steel", 32'(ram[767]), 32'd3);
    check("ram_100_bg", 32'(ram[100]), 32'd0);
    check("ram_495_brick", 32'(ram[495]), 32'd1);

    // Brick, repeat, steel, grass, out of bounds
    hit(110, 105);
    drain();
    check("ram_165_destroyed", 32'(ram[165]), 32'd0);
    hit(110, 105);
    hit(5, 300);
    hit(250, 205);
    hit(640, 0);
    hit(0, 480);
    drain();

    // Random in-range and slightly out-of-range hits
    for (int i = 0; i < 8; i++)
      hit(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
    drain();

    // HitValid held through a fresh INIT, then queued requests
    @(negedge Clk);
    Reset_n = 1'b0;
    HitX = 10'd19;
    HitY = 10'd19;
    HitValid = 1'b1;
    #1 check_reset_outputs();
    clear_sb();
    mdl = lay;
    @(negedge Clk);
    Reset_n = 1'b1;
    hit(19, 19);
    hit(639, 479);
    hit(300, 300);
    hit(1000, 1000);
    drain();
    check("ram_495_destroyed", 32'(ram[495]), 32'd0);

    // Reset during a brick WRITE cycle
    hit(410, 410);
    n = 0;
    while (!(MapWe && InitDone) && n < 10) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("reached_write", 32'(MapWe), 32'd1);
    Reset_n = 1'b0;
    #1 check_reset_outputs();
    clear_sb();
    mdl = lay;
    repeat (4) @(negedge Clk);
    Reset_n = 1'b1;
    wait_init();
    check("ram_495_restored", 32'(ram[495]), 32'd1);
    check("ram_660_intact", 32'(ram[660]), 32'd1);
    check("ram_165_restored", 32'(ram[165]), 32'd1);
    hit(110, 105);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
